// File: rtl/vend_if.sv
// rtl/vend_if.sv - front-end/back-end signal bundle for the vending controller

interface vend_if;
  // coin acceptor / keypad / motor driver inputs
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic [3:0] stock_empty;
  logic       dispense_ack;
  // controller outputs
  logic [7:0] credit;
  logic       dispense_req;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       err_soldout;
  logic       err_funds;
  logic       err_fault;
  logic       busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_item, cancel, stock_empty, dispense_ack,
    input  credit, dispense_req, dispense_item, change_valid, change_coin,
           coin_reject, err_soldout, err_funds, err_fault, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_item, cancel, stock_empty, dispense_ack,
    output credit, dispense_req, dispense_item, change_valid, change_coin,
           coin_reject, err_soldout, err_funds, err_fault, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending machine credit/select/dispense/change sequencer

module vend_ctrl #(
  parameter int CREDIT_MAX   = 200,
  parameter int PRICE0       = 25,
  parameter int PRICE1       = 50,
  parameter int PRICE2       = 75,
  parameter int PRICE3       = 100,
  parameter int DISP_TIMEOUT = 15
) (
  input logic   clk,
  input logic   rst_n,
  vend_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [1:0] item_q, item_d;
  logic [7:0] timer_q, timer_d;
  logic       reject_q, reject_d;
  logic       soldout_q, soldout_d;
  logic       funds_q, funds_d;
  logic       fault_q, fault_d;
  logic       change_valid;
  logic [1:0] change_coin;

  function automatic logic [8:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = 9'd5;
      2'b01:   coin_value = 9'd10;
      2'b10:   coin_value = 9'd25;
      default: coin_value = 9'd100;
    endcase
  endfunction

  function automatic logic [7:0] item_price(input logic [1:0] i);
    case (i)
      2'd0:    item_price = 8'(PRICE0);
      2'd1:    item_price = 8'(PRICE1);
      2'd2:    item_price = 8'(PRICE2);
      default: item_price = 8'(PRICE3);
    endcase
  endfunction

  // Sum is 9 bits wide so a 100c coin on top of 200c is seen as over the cap.
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic [7:0] eff_credit;
  logic [7:0] sel_price;

  assign coin_sum   = {1'b0, credit_q} + coin_value(bus.coin_type);
  assign coin_ok    = bus.coin_valid && (coin_sum <= 9'(CREDIT_MAX));
  assign eff_credit = coin_ok ? coin_sum[7:0] : credit_q;
  assign sel_price  = item_price(bus.sel_item);

  // Greedy change coin for the current credit
  logic [7:0] pick_val;
  logic [1:0] pick_code;
  always_comb begin
    pick_val  = 8'd5;
    pick_code = 2'b00;
    if (credit_q >= 8'd25) begin
      pick_val  = 8'd25;
      pick_code = 2'b10;
    end else if (credit_q >= 8'd10) begin
      pick_val  = 8'd10;
      pick_code = 2'b01;
    end
  end

  // State, credit and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      credit_q  <= 8'd0;
      item_q    <= 2'd0;
      timer_q   <= 8'd0;
      reject_q  <= 1'b0;
      soldout_q <= 1'b0;
      funds_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      item_q    <= item_d;
      timer_q   <= timer_d;
      reject_q  <= reject_d;
      soldout_q <= soldout_d;
      funds_q   <= funds_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state, credit update and change issue
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    item_d       = item_q;
    timer_d      = timer_q;
    reject_d     = 1'b0;
    soldout_d    = 1'b0;
    funds_d      = 1'b0;
    fault_d      = 1'b0;
    change_valid = 1'b0;
    change_coin  = 2'b00;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (bus.cancel && credit_q != 8'd0) begin
          // refund wins; a coin arriving alongside goes straight back
          reject_d = bus.coin_valid;
          state_d  = S_CHANGE;
        end else begin
          credit_d = eff_credit;
          reject_d = bus.coin_valid && !coin_ok;
          state_d  = (eff_credit != 8'd0) ? S_CREDIT : S_IDLE;
          if (bus.sel_valid) begin
            if (bus.stock_empty[bus.sel_item]) begin
              soldout_d = 1'b1;
            end else if (eff_credit < sel_price) begin
              funds_d = 1'b1;
            end else begin
              credit_d = eff_credit - sel_price;
              item_d   = bus.sel_item;
              timer_d  = 8'd0;
              state_d  = S_DISPENSE;
            end
          end
        end
      end
      S_DISPENSE: begin
        reject_d = bus.coin_valid;
        if (bus.dispense_ack) begin
          state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
        end else if (timer_q == 8'(DISP_TIMEOUT - 1)) begin
          // motor never answered: give the price back and refund everything
          credit_d = credit_q + item_price(item_q);
          fault_d  = 1'b1;
          state_d  = S_CHANGE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        reject_d = bus.coin_valid;
        if (credit_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          change_valid = 1'b1;
          change_coin  = pick_code;
          credit_d     = credit_q - pick_val;
          if (credit_q == pick_val) state_d = S_IDLE;
        end
      end
    endcase
  end

  assign bus.credit        = credit_q;
  assign bus.dispense_req  = (state_q == S_DISPENSE);
  assign bus.dispense_item = (state_q == S_DISPENSE) ? item_q : 2'b00;
  assign bus.change_valid  = change_valid;
  assign bus.change_coin   = change_coin;
  assign bus.coin_reject   = reject_q;
  assign bus.err_soldout   = soldout_q;
  assign bus.err_funds     = funds_q;
  assign bus.err_fault     = fault_q;
  assign bus.busy          = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed vector bench for vend_ctrl

module tb_vend_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_if bus ();

  vend_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // packed observation: {credit, req, item, chg_valid, chg_coin, reject, soldout, funds, fault, busy}
  typedef struct {
    string      name;
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] si;
    logic       cn;
    logic [3:0] se;
    logic       ak;
    logic [18:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[18];

  function automatic logic [18:0] pack(input logic [7:0] cr, input logic rq, input logic [1:0] it,
                                       input logic chv, input logic [1:0] chc,
                                       input logic [3:0] flags, input logic bz);
    pack = {cr, rq, it, chv, chc, flags, bz};
  endfunction

  function automatic vec_t mk(input string nm, input logic cv, input logic [1:0] ct,
                              input logic sv, input logic [1:0] si, input logic cn,
                              input logic [3:0] se, input logic ak, input logic [18:0] e);
    vec_t v;
    v.name = nm; v.cv = cv; v.ct = ct; v.sv = sv; v.si = si;
    v.cn = cn; v.se = se; v.ak = ak; v.exp = e;
    return v;
  endfunction

  function automatic logic [18:0] observe();
    observe = {bus.credit, bus.dispense_req, bus.dispense_item, bus.change_valid, bus.change_coin,
               bus.coin_reject, bus.err_soldout, bus.err_funds, bus.err_fault, bus.busy};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] si,
                       input logic cn, input logic [3:0] se, input logic ak);
    bus.coin_valid   = cv;
    bus.coin_type    = ct;
    bus.sel_valid    = sv;
    bus.sel_item     = si;
    bus.cancel       = cn;
    bus.stock_empty  = se;
    bus.dispense_ack = ak;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] ct);
    drive(1'b1, ct, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
  endtask

  // Walk through a change burst, one expected coin per cycle, then expect IDLE
  task automatic drain(input string nm, input logic [1:0] coins[8], input int n);
    for (int i = 0; i < n; i++) begin
      check({nm, "_chg_valid"}, 32'(bus.change_valid), 32'd1);
      check({nm, "_chg_coin"}, 32'(bus.change_coin), 32'(coins[i]));
      idle();
      step();
    end
    check({nm, "_end_valid"}, 32'(bus.change_valid), 32'd0);
    check({nm, "_end_credit"}, 32'(bus.credit), 32'd0);
    check({nm, "_end_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] coins[8];
    int cnt;

    vecs[0]  = mk("coin25a",      1, 2'b10, 0, 2'd0, 0, 4'b0000, 0, pack(8'd25,  0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[1]  = mk("coin25b",      1, 2'b10, 0, 2'd0, 0, 4'b0000, 0, pack(8'd50,  0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[2]  = mk("coin10",       1, 2'b01, 0, 2'd0, 0, 4'b0000, 0, pack(8'd60,  0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[3]  = mk("sel_item1",    0, 2'b00, 1, 2'd1, 0, 4'b0000, 0, pack(8'd10,  1, 2'd1, 0, 2'b00, 4'b0000, 1));
    vecs[4]  = mk("wait_ack",     0, 2'b00, 0, 2'd0, 0, 4'b0000, 0, pack(8'd10,  1, 2'd1, 0, 2'b00, 4'b0000, 1));
    vecs[5]  = mk("ack_change",   0, 2'b00, 0, 2'd0, 0, 4'b0000, 1, pack(8'd10,  0, 2'd0, 1, 2'b01, 4'b0000, 1));
    vecs[6]  = mk("change_done",  0, 2'b00, 0, 2'd0, 0, 4'b0000, 0, pack(8'd0,   0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[7]  = mk("coin25c",      1, 2'b10, 0, 2'd0, 0, 4'b0000, 0, pack(8'd25,  0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[8]  = mk("low_funds",    0, 2'b00, 1, 2'd2, 0, 4'b0000, 0, pack(8'd25,  0, 2'd0, 0, 2'b00, 4'b0010, 0));
    vecs[9]  = mk("soldout_prio", 0, 2'b00, 1, 2'd2, 0, 4'b0100, 0, pack(8'd25,  0, 2'd0, 0, 2'b00, 4'b0100, 0));
    vecs[10] = mk("coin_and_sel", 1, 2'b10, 1, 2'd1, 0, 4'b0000, 0, pack(8'd0,   1, 2'd1, 0, 2'b00, 4'b0000, 1));
    vecs[11] = mk("ack_no_chg",   0, 2'b00, 0, 2'd0, 0, 4'b0000, 1, pack(8'd0,   0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[12] = mk("coin100a",     1, 2'b11, 0, 2'd0, 0, 4'b0000, 0, pack(8'd100, 0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[13] = mk("soldout",      0, 2'b00, 1, 2'd2, 0, 4'b0100, 0, pack(8'd100, 0, 2'd0, 0, 2'b00, 4'b0100, 0));
    vecs[14] = mk("coin100b",     1, 2'b11, 0, 2'd0, 0, 4'b0000, 0, pack(8'd200, 0, 2'd0, 0, 2'b00, 4'b0000, 0));
    vecs[15] = mk("over_max",     1, 2'b00, 0, 2'd0, 0, 4'b0000, 0, pack(8'd200, 0, 2'd0, 0, 2'b00, 4'b1000, 0));
    vecs[16] = mk("sel_item3",    0, 2'b00, 1, 2'd3, 0, 4'b0100, 0, pack(8'd100, 1, 2'd3, 0, 2'b00, 4'b0000, 1));
    vecs[17] = mk("coin_in_disp", 1, 2'b00, 0, 2'd0, 0, 4'b0000, 0, pack(8'd100, 1, 2'd3, 0, 2'b00, 4'b1000, 1));

    idle();
    #12;
    check("reset_outputs", 32'(observe()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].cv, vecs[i].ct, vecs[i].sv, vecs[i].si, vecs[i].cn, vecs[i].se, vecs[i].ak);
      step();
      check(vecs[i].name, 32'(observe()), 32'(vecs[i].exp));
    end

    // asynchronous reset while the motor request is up
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_credit", 32'(bus.credit), 32'd0);
    check("rst_req", 32'(bus.dispense_req), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(observe()), 32'd0);

    // dispense timeout with full refund
    coin(2'b11);
    check("to_credit", 32'(bus.credit), 32'd100);
    drive(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
    check("to_after_sel", 32'(bus.credit), 32'd75);
    cnt = 0;
    for (int i = 0; i < 40 && bus.dispense_req; i++) begin
      cnt++;
      idle();
      step();
    end
    check("to_req_cycles", 32'(cnt), 32'd15);
    check("to_fault", 32'(bus.err_fault), 32'd1);
    check("to_refund", 32'(bus.credit), 32'd100);
    coins[0] = 2'b10; coins[1] = 2'b10; coins[2] = 2'b10; coins[3] = 2'b10;
    coins[4] = 2'b00; coins[5] = 2'b00; coins[6] = 2'b00; coins[7] = 2'b00;
    drain("to", coins, 4);
    check("to_fault_cleared", 32'(bus.err_fault), 32'd0);

    // cancel with a same-cycle coin
    coin(2'b10);
    coin(2'b01);
    coin(2'b00);
    check("cn_credit", 32'(bus.credit), 32'd40);
    drive(1'b1, 2'b10, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    step();
    check("cn_reject", 32'(bus.coin_reject), 32'd1);
    check("cn_credit_kept", 32'(bus.credit), 32'd40);
    coins[0] = 2'b10; coins[1] = 2'b01; coins[2] = 2'b00;
    drain("cn", coins, 3);

    // cancel with no credit does nothing
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    step();
    check("cn_zero_idle", 32'(observe()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
